// File: rtl/alu_pkg.sv
// Shared ALU definitions for the filter datapath: opcode encoding, the
// flag bundle returned by the shared ALU, and the response-slot states.
package alu_pkg;

  localparam int ALU_N  = 18;
  localparam int ALU_FW = 3;

  // Encodings 101..111 are not listed; the ALU treats them as MUL.
  typedef enum logic [ALU_FW-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_MUL = 3'b100
  } alu_op_e;

  typedef struct packed {
    logic neg;
    logic zero;
    logic carry;
    logic ovf;
  } alu_flags_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the filter lanes and the ALU share
// arbiter. The master side belongs to the requesters and the response
// consumer; the slave side belongs to the arbiter.
interface alu_share_arbiter_if #(
  parameter int N   = 18,
  parameter int REQ = 4,
  parameter int IDW = $clog2(REQ)
);

  logic [REQ-1:0]   req_valid;
  logic [REQ-1:0]   req_ready;
  logic [REQ*N-1:0] req_a;
  logic [REQ*N-1:0] req_b;
  logic [REQ*3-1:0] req_f;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [N-1:0]     rsp_result;
  logic [3:0]       rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_f, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_f, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, wrapping modulo REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int REQ = 4,
  localparam int IDW = $clog2(REQ)
) (
  input  logic [REQ-1:0] req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [REQ-1:0] gnt,
  output logic [IDW-1:0] gnt_idx
);

  // Scan requesters starting from the pointer; the first hit wins.
  always_comb begin : pick
    logic found;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= REQ) idx = idx - REQ;
      if (en && !found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among REQ filter lanes. A round-robin grant
// steers the winner's operands to the ALU and the ALU output is captured
// into a single response slot tagged with the requester ID.
// Optional feature: define ALU_STICKY_OVF_EN to add per-requester sticky
// overflow bits (ovf_sticky) with per-bit clear (ovf_clr).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N   = ALU_N,
  parameter int REQ = 4,
  parameter int IDW = $clog2(REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [ALU_FW-1:0] alu_f,
  input  logic [N-1:0]      alu_result,
  input  logic [3:0]        alu_flags
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic [REQ-1:0]    ovf_sticky,
  input  logic [REQ-1:0]    ovf_clr
`endif
);

  slot_state_e    state_p1;
  logic [IDW-1:0] ptr_p1;
  logic [IDW-1:0] id_p1;
  logic [N-1:0]   result_p1;
  alu_flags_t     flags_p1;

  logic           slot_free_p0;
  logic [REQ-1:0] gnt_p0;
  logic [IDW-1:0] gnt_idx_p0;
  logic           gnt_any_p0;
  alu_flags_t     alu_flags_p0;

  // Stage p0: arbitration and operand steering (combinational)
  // A grant is only possible when the slot is empty or draining this cycle;
  // holding rst_n in the enable keeps req_ready low throughout reset.
  assign slot_free_p0 = (state_p1 == SLOT_EMPTY) | bus.rsp_ready;

  rr_arbiter #(.REQ(REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_p1),
    .en      (slot_free_p0 & rst_n),
    .gnt     (gnt_p0),
    .gnt_idx (gnt_idx_p0)
  );

  assign gnt_any_p0    = |gnt_p0;
  assign bus.req_ready = gnt_p0;
  assign alu_flags_p0  = alu_flags_t'(alu_flags);

  // gnt_idx is 0 with no grant, so idle cycles deterministically show lane 0.
  assign alu_a = bus.req_a[int'(gnt_idx_p0)*N +: N];
  assign alu_b = bus.req_b[int'(gnt_idx_p0)*N +: N];
  assign alu_f = bus.req_f[int'(gnt_idx_p0)*ALU_FW +: ALU_FW];

  // Stage p1: response slot
  // Slot FSM plus capture of the granted ALU result and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= SLOT_EMPTY;
      ptr_p1    <= '0;
      id_p1     <= '0;
      result_p1 <= '0;
      flags_p1  <= '0;
    end else begin
      if (gnt_any_p0) begin
        id_p1     <= gnt_idx_p0;
        result_p1 <= alu_result;
        flags_p1  <= alu_flags_p0;
        ptr_p1    <= (int'(gnt_idx_p0) == REQ - 1) ? '0 : gnt_idx_p0 + 1'b1;
      end
      case (state_p1)
        SLOT_EMPTY: if (gnt_any_p0) state_p1 <= SLOT_FULL;
        SLOT_FULL:  if (bus.rsp_ready && !gnt_any_p0) state_p1 <= SLOT_EMPTY;
        default:    state_p1 <= SLOT_EMPTY;
      endcase
    end
  end

  assign bus.rsp_valid  = (state_p1 == SLOT_FULL);
  assign bus.rsp_id     = id_p1;
  assign bus.rsp_result = result_p1;
  assign bus.rsp_flags  = flags_p1;

`ifdef ALU_STICKY_OVF_EN
  logic [REQ-1:0] ovf_set_p0;

  assign ovf_set_p0 = gnt_p0 & {REQ{alu_flags_p0.ovf}};

  // Sticky overflow per requester; a capture with overflow beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= '0;
    end else begin
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | ovf_set_p0;
    end
  end
`endif

endmodule
